// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate enable, scan counters, and registered sync/blanking
// flags derived from next-state counters so they always match pixel_x/pixel_y.
module vga_sync_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   // Totals must stay <= 1024 so the 10-bit counters cover the full raster.
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS   = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS   = 10'(V_DISPLAY);
   localparam logic [9:0] HS_LO   = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_HI   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_LO   = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_HI   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [9:0]       x_nxt, y_nxt;
   logic             x_wrap, y_wrap;

   always_comb begin
      p_tick  = !rst && (div_cnt == DIV_LAST);
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      x_wrap  = (pixel_x == H_LAST);
      y_wrap  = (pixel_y == V_LAST);
      x_nxt   = pixel_x;
      y_nxt   = pixel_y;
      if (p_tick) begin
         x_nxt = x_wrap ? 10'd0 : pixel_x + 10'd1;
         if (x_wrap)
            y_nxt = y_wrap ? 10'd0 : pixel_y + 10'd1;
      end
   end

   // Flags are registered from x_nxt/y_nxt: zero lag relative to the counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt     <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt     <= div_nxt;
         pixel_x     <= x_nxt;
         pixel_y     <= y_nxt;
         hsync       <= !((x_nxt >= HS_LO) && (x_nxt <= HS_HI));
         vsync       <= !((y_nxt >= VS_LO) && (y_nxt <= VS_HI));
         video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         frame_start <= p_tick && x_wrap && y_wrap;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default build, CLK_DIV=1 build, and a shrunken raster
// for whole-frame and mid-frame reset scenarios; closed-form model via scoreboard.
`timescale 1ns/1ps
module tb_vga_sync_gen;

   typedef struct {
      logic [9:0] x, y;
      logic hs, vs, vo, pt, fs;
   } smp_t;

   typedef struct {
      int   id;
      int   c;
      smp_t e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst [3];
   logic       hs [3], vs [3], vo [3], pt [3], fs [3];
   logic [9:0] px [3], py [3];

   int total = 0, bad = 0;
   smp_t sb_q [$];
   vec_t tbl [18];
   int   hs_low, hs_first, vs_low, fs_cnt, fs_first, max_y, tbl_hits;

   always #5 clk = ~clk;

   vga_sync_gen u_def (.clk(clk), .rst(rst[0]), .hsync(hs[0]), .vsync(vs[0]),
      .video_on(vo[0]), .p_tick(pt[0]), .pixel_x(px[0]), .pixel_y(py[0]), .frame_start(fs[0]));

   vga_sync_gen #(.CLK_DIV(1)) u_div1 (.clk(clk), .rst(rst[1]), .hsync(hs[1]), .vsync(vs[1]),
      .video_on(vo[1]), .p_tick(pt[1]), .pixel_x(px[1]), .pixel_y(py[1]), .frame_start(fs[1]));

   vga_sync_gen #(.CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_small (.clk(clk), .rst(rst[2]),
      .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]), .p_tick(pt[2]), .pixel_x(px[2]),
      .pixel_y(py[2]), .frame_start(fs[2]));

   function automatic smp_t mk_s(int x, int y, bit h, bit v, bit o, bit p, bit f);
      smp_t s;
      s.x = 10'(x); s.y = 10'(y); s.hs = h; s.vs = v; s.vo = o; s.pt = p; s.fs = f;
      return s;
   endfunction

   function automatic vec_t mk(int id, int c, int x, int y, bit h, bit v, bit o, bit p, bit f);
      vec_t r;
      r.id = id; r.c = c; r.e = mk_s(x, y, h, v, o, p, f);
      return r;
   endfunction

   // Expected outputs in cycle c after release (cycle 0 = before the first edge).
   function automatic smp_t model(int id, int c);
      int dv, hd, hf, hw, hb, vd, vf, vw, vb, ht, vt, n, x, y;
      smp_t e;
      dv = 4; hd = 640; hf = 16; hw = 96; hb = 48; vd = 480; vf = 10; vw = 2; vb = 33;
      if (id == 1) dv = 1;
      if (id == 2) begin
         dv = 2; hd = 8; hf = 2; hw = 3; hb = 2; vd = 6; vf = 2; vw = 2; vb = 3;
      end
      ht = hd + hf + hw + hb;
      vt = vd + vf + vw + vb;
      n  = c / dv;
      x  = n % ht;
      y  = (n / ht) % vt;
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.hs = !(x >= hd + hf && x < hd + hf + hw);
      e.vs = !(y >= vd + vf && y < vd + vf + vw);
      e.vo = (c > 0) && (x < hd) && (y < vd);
      e.pt = (c % dv) == dv - 1;
      e.fs = (c > 0) && (c % dv == 0) && (n > 0) && (n % (ht * vt) == 0);
      return e;
   endfunction

   function automatic smp_t obs(int id);
      return mk_s(int'(px[id]), int'(py[id]), hs[id], vs[id], vo[id], pt[id], fs[id]);
   endfunction

   task automatic cmp(string name, int c, smp_t g, smp_t w);
      total++;
      if (g !== w) begin
         bad++;
         $display("FAIL %s c=%0d got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fs=%b want x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fs=%b",
                  name, c, g.x, g.y, g.hs, g.vs, g.vo, g.pt, g.fs, w.x, w.y, w.hs, w.vs, w.vo, w.pt, w.fs);
      end
   endtask

   task automatic cmp_int(string name, int g, int w);
      total++;
      if (g != w) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, g, w);
      end
   endtask

   // Called at a negedge: hold reset n cycles checking reset values, release at a negedge.
   task automatic hold_reset(int id, int n);
      rst[id] = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1 cmp("reset_hold", i, obs(id), mk_s(0, 0, 1, 1, 0, 0, 0));
         @(negedge clk);
      end
      rst[id] = 1'b0;
   endtask

   task automatic run_check(int id, int n);
      smp_t g, w;
      hs_low = 0; hs_first = -1; vs_low = 0; fs_cnt = 0; fs_first = -1; max_y = 0; tbl_hits = 0;
      for (int c = 0; c < n; c++) begin
         sb_q.push_back(model(id, c));
         #1;
         g = obs(id);
         w = sb_q.pop_front();
         cmp("scan", c, g, w);
         foreach (tbl[k])
            if (tbl[k].id == id && tbl[k].c == c) begin
               cmp("vec", c, g, tbl[k].e);
               tbl_hits++;
            end
         if (c < 800 && !g.hs) begin
            hs_low++;
            if (hs_first < 0) hs_first = c;
         end
         if (c < 390 && !g.vs) vs_low++;
         if (g.fs) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = c;
         end
         if (int'(g.y) > max_y) max_y = int'(g.y);
         @(negedge clk);
      end
   endtask

   // At a negedge: assert reset between edges and expect immediate reset values.
   task automatic async_reset(int id, int c_now);
      #1 cmp("pre_async", c_now, obs(id), model(id, c_now));
      #1 rst[id] = 1'b1;
      #1 cmp("async_rst", c_now, obs(id), mk_s(0, 0, 1, 1, 0, 0, 0));
      @(negedge clk);
   endtask

   initial begin
      rst[0] = 1'b1; rst[1] = 1'b1; rst[2] = 1'b1;
      // default build: reset-hold sequence and line timing points
      tbl[0]  = mk(0, 0,    0,   0, 1, 1, 0, 0, 0);
      tbl[1]  = mk(0, 1,    0,   0, 1, 1, 1, 0, 0);
      tbl[2]  = mk(0, 3,    0,   0, 1, 1, 1, 1, 0);
      tbl[3]  = mk(0, 4,    1,   0, 1, 1, 1, 0, 0);
      tbl[4]  = mk(0, 2559, 639, 0, 1, 1, 1, 1, 0);
      tbl[5]  = mk(0, 2560, 640, 0, 1, 1, 0, 0, 0);
      tbl[6]  = mk(0, 2623, 655, 0, 1, 1, 0, 1, 0);
      tbl[7]  = mk(0, 2624, 656, 0, 0, 1, 0, 0, 0);
      tbl[8]  = mk(0, 3007, 751, 0, 0, 1, 0, 1, 0);
      tbl[9]  = mk(0, 3008, 752, 0, 1, 1, 0, 0, 0);
      tbl[10] = mk(0, 3199, 799, 0, 1, 1, 0, 1, 0);
      tbl[11] = mk(0, 3200, 0,   1, 1, 1, 1, 0, 0);
      // shrunken raster (15x13, div 2): blanking edges and the frame wrap
      tbl[12] = mk(2, 164,  7,  5, 1, 1, 1, 0, 0);
      tbl[13] = mk(2, 166,  8,  5, 1, 1, 0, 0, 0);
      tbl[14] = mk(2, 180,  0,  6, 1, 1, 0, 0, 0);
      tbl[15] = mk(2, 389, 14, 12, 1, 1, 0, 1, 0);
      tbl[16] = mk(2, 390,  0,  0, 1, 1, 1, 0, 1);
      tbl[17] = mk(2, 391,  0,  0, 1, 1, 1, 1, 0);

      @(negedge clk);
      hold_reset(0, 10);
      run_check(0, 3300);
      cmp_int("def_vec_hits", tbl_hits, 12);
      cmp_int("def_max_y", max_y, 1);

      hold_reset(0, 3);
      run_check(0, 2801);            // now at pixel (700,0), hsync low
      async_reset(0, 2801);
      hold_reset(0, 2);
      run_check(0, 400);
      cmp_int("def_restart_hits", tbl_hits, 4);

      hold_reset(1, 10);
      run_check(1, 1600);
      cmp_int("div1_hs_low", hs_low, 96);
      cmp_int("div1_hs_first", hs_first, 656);

      hold_reset(2, 10);
      run_check(2, 800);
      cmp_int("small_vec_hits", tbl_hits, 6);
      cmp_int("small_vs_low", vs_low, 60);
      cmp_int("small_fs_cnt", fs_cnt, 2);
      cmp_int("small_fs_first", fs_first, 390);
      cmp_int("small_max_y", max_y, 12);

      hold_reset(2, 3);
      run_check(2, 263);             // now at pixel (11,8), both syncs low
      async_reset(2, 263);
      hold_reset(2, 2);
      run_check(2, 400);
      cmp_int("small_restart_fs", fs_first, 390);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates the VGA 640x480@60 Hz timing for the display path. Produces hsync and vsync, the video_on blanking flag, and the pixel_x/pixel_y coordinates consumed by the character renderer. It divides the system clock into a pixel-rate tick and runs the horizontal and vertical scan counters from that tick. The character renderer and font ROM sit downstream and are driven only by this block's outputs.

## Interface
- CLK_DIV, 4: system clocks per pixel; 100 MHz in gives a 25 MHz pixel rate; legal range 1..16.
- H_DISPLAY, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_DISPLAY, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- clk  input  1  system clock; the block uses only this clock.
- rst  input  1  reset, asynchronous and active-high.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- video_on  output  1  high while the current pixel is inside the visible area.
- p_tick  output  1  pixel-rate enable, high one clk in every CLK_DIV.
- pixel_x  output  10  horizontal count, 0..H_TOTAL-1.
- pixel_y  output  10  vertical count, 0..V_TOTAL-1.
- frame_start  output  1  one-clk pulse when the counters wrap to (0,0).

## Operation
- H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤1024.
- div_cnt counts 0..CLK_DIV-1 and wraps.
- p_tick = (div_cnt == CLK_DIV-1) and not rst. With CLK_DIV=1, p_tick is constantly high outside reset.
- Counters advance only on a clk edge where p_tick=1.
  - pixel_x increments and wraps H_TOTAL-1 → 0.
  - pixel_y increments only when pixel_x wraps, and wraps V_TOTAL-1 → 0.
  - Arithmetic is unsigned 10-bit; no other wrap points exist.
- hsync = 0 iff pixel_x ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751] with defaults.
- vsync = 0 iff pixel_y ∈ [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. [490,491] with defaults.
- video_on = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY).
- hsync, vsync and video_on are registered. They are computed from the next-state counter values, so they are glitch-free and always consistent with the pixel_x/pixel_y shown in the same cycle.
- frame_start is registered: it is high for exactly the one clk following the edge where pixel_x and pixel_y both wrap to 0.

## Timing
- Reset values: div_cnt=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0, p_tick=0, frame_start=0.
- Reset is asynchronous: all outputs take their reset values immediately, independent of clk.
- Reset asserted mid-frame aborts the scan. On release, scanning restarts from (0,0) with no stale sync pulse.
- First clk edge after reset release: video_on=1, since the next counters are (0,0). frame_start stays 0 on this edge, because the counters did not wrap.
- First p_tick occurs CLK_DIV clks after release; it is in cycle index CLK_DIV-1, counting the first post-release cycle as 0.
- The first increment of pixel_x lands on that p_tick edge.
- Each pixel value is held for exactly CLK_DIV clks.
- Line period = H_TOTAL × CLK_DIV clks (3200). Frame period = H_TOTAL × V_TOTAL × CLK_DIV clks (1,680,000).
- hsync and vsync change on the same edge as the pixel_x/pixel_y value that defines them; there is zero lag.
- Simultaneous wrap of pixel_x and pixel_y:
  - both go to 0 on one edge;
  - vsync and hsync are already 1 there;
  - video_on rises on that edge;
  - frame_start pulses in the next clk only.

## Test plan
- Reset hold: assert rst for 10 clks, then drop it → all outputs at their reset values throughout; video_on=1 one clk after release; first p_tick at clk 3 after release; pixel_x=1 at clk 4.
- Line timing: run one line → hsync falls on the edge where pixel_x becomes 656 and rises where it becomes 752, i.e. 384 clks low; video_on falls at pixel_x=640; pixel_y increments after 3200 clks.
- Frame timing: run a full frame → vsync low exactly while pixel_y ∈ {490,491}, i.e. 6400 clks; frame_start single-clk pulse at clk 1,680,000 after the first wrap-free start; pixel_y never reaches 525.
- Blanking check: at (639,479) video_on=1; at (640,479) and (0,480) video_on=0; at (799,524)→(0,0) video_on returns to 1.
- Reset mid-operation: assert rst asynchronously at pixel (700,491), while both syncs are low → hsync=vsync=1 and counters=0 within the same clk, without waiting for a clk edge; after release, the sequence restarts identically to the reset-hold scenario.
- CLK_DIV=1 build: p_tick high every clk after release; line = 800 clks; hsync low for 96 clks starting at clk 656 of each line.
